// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : writeback_stage
// Purpose  : RISC-V writeback stage. A result FIFO absorbs register-file stalls,
//            then load sign/zero extension drives the register-file write port.
// Option   : define WB_RETIRE_COUNTER_EN to build the retired-beat counter.
// Revision : 1.0 - initial release
// ============================================================================
module writeback_stage #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        axis_s_data_tvalid,
  output logic        axis_s_data_tready,
  input  logic [31:0] axis_s_data_tdata,
  input  logic [16:0] ctrl_data_i,
  input  logic        stall_i,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] retired_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic [31:0]      fifo_data [DEPTH];
  logic [16:0]      fifo_ctrl [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             tready_q;
  logic             push;
  logic             pop;

  logic [31:0]      head_data;
  logic [16:0]      head_ctrl;
  logic [6:0]       head_op;
  logic [2:0]       head_f3;
  logic [4:0]       head_rd;
  logic [1:0]       head_off;
  logic [7:0]       sel_byte;
  logic [15:0]      sel_half;
  logic [31:0]      ext_data;
  logic             head_writes;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // tready is a flop so upstream never sees a combinational path from tvalid/stall.
  assign axis_s_data_tready = tready_q;
  assign push = axis_s_data_tvalid && tready_q;
  assign pop  = (count != '0) && !stall_i;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tready_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count    <= count_next;
      tready_q <= (count_next < CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= axis_s_data_tdata;
      fifo_ctrl[wr_ptr] <= ctrl_data_i;
    end
  end

  assign head_data = fifo_data[rd_ptr];
  assign head_ctrl = fifo_ctrl[rd_ptr];
  assign head_op   = head_ctrl[6:0];
  assign head_f3   = head_ctrl[9:7];
  assign head_rd   = head_ctrl[14:10];
  assign head_off  = head_ctrl[16:15];

  always_comb begin
    sel_byte = head_data[7:0];
    case (head_off)
      2'd0:    sel_byte = head_data[7:0];
      2'd1:    sel_byte = head_data[15:8];
      2'd2:    sel_byte = head_data[23:16];
      default: sel_byte = head_data[31:24];
    endcase
    // Halfword loads ignore off[0]; misaligned halves are not split.
    sel_half = head_off[1] ? head_data[31:16] : head_data[15:0];

    ext_data = head_data;
    if (head_op == OP_LOAD) begin
      case (head_f3)
        F3_LB:   ext_data = {{24{sel_byte[7]}}, sel_byte};
        F3_LBU:  ext_data = {24'd0, sel_byte};
        F3_LH:   ext_data = {{16{sel_half[15]}}, sel_half};
        F3_LHU:  ext_data = {16'd0, sel_half};
        default: ext_data = head_data;
      endcase
    end

    head_writes = (head_op != OP_STORE) && (head_op != OP_BRANCH) && (head_rd != 5'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= pop && head_writes;
      if (pop && head_writes) begin
        rf_waddr <= head_rd;
        rf_wdata <= ext_data;
      end
    end
  end

`ifdef WB_RETIRE_COUNTER_EN
  logic [31:0] retired_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= '0;
    end else if (pop) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign retired_count = retired_q;
`else
  assign retired_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_stage
// Purpose  : Randomized bench for writeback_stage against a queue-based model,
//            plus directed beats with hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_stage;

  localparam int DEPTH = 2;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] STORE  = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tvalid = 1'b0;
  logic        tready;
  logic [31:0] tdata = '0;
  logic [16:0] ctrl = '0;
  logic        stall = 1'b0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] retired;

  always #5 clk = ~clk;

  writeback_stage #(.DEPTH(DEPTH)) dut (
    .clk                (clk),
    .rst                (rst),
    .axis_s_data_tvalid (tvalid),
    .axis_s_data_tready (tready),
    .axis_s_data_tdata  (tdata),
    .ctrl_data_i        (ctrl),
    .stall_i            (stall),
    .rf_we              (rf_we),
    .rf_waddr           (rf_waddr),
    .rf_wdata           (rf_wdata),
    .retired_count      (retired)
  );

  // Reference model: a queue of {ctrl, data} beats plus expected output values.
  logic [48:0] q[$];
  logic        m_we;
  logic        m_tready;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic [31:0] m_retired;
  bit          last_push;

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [16:0] mk(input int off, input int rd, input int f3, input logic [6:0] op);
    logic [1:0] o;
    logic [4:0] r;
    logic [2:0] f;
    o = 2'(off);
    r = 5'(rd);
    f = 3'(f3);
    return {o, r, f, op};
  endfunction

  function automatic logic [31:0] exp_data(input logic [31:0] d, input logic [16:0] c);
    int off;
    logic [31:0] b;
    logic [31:0] h;
    off = int'(c[16:15]);
    b = (d >> (8 * off)) & 32'hFF;
    h = (d >> (16 * (off / 2))) & 32'hFFFF;
    if (c[6:0] != LOAD) return d;
    case (c[9:7])
      3'b000:  return (b > 32'd127) ? (b | 32'hFFFF_FF00) : b;
      3'b100:  return b;
      3'b001:  return (h > 32'd32767) ? (h | 32'hFFFF_0000) : h;
      3'b101:  return h;
      default: return d;
    endcase
  endfunction

  function automatic bit writes_rf(input logic [16:0] c);
    return (c[6:0] != 7'b0100011) && (c[6:0] != 7'b1100011) && (c[14:10] != 5'd0);
  endfunction

  function automatic logic [31:0] exp_retired();
`ifdef WB_RETIRE_COUNTER_EN
    return m_retired;
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    m_we      = 1'b0;
    m_tready  = 1'b0;
    m_waddr   = '0;
    m_wdata   = '0;
    m_retired = '0;
    last_push = 1'b0;
  endtask

  task automatic model_edge();
    bit          do_push;
    bit          do_pop;
    logic [48:0] b;
    logic [16:0] c;
    if (rst) begin
      model_reset();
      return;
    end
    do_push   = tvalid && m_tready;
    do_pop    = (q.size() > 0) && !stall;
    last_push = do_push;
    m_we      = 1'b0;
    if (do_pop) begin
      b = q.pop_front();
      c = b[48:32];
      m_retired = m_retired + 32'd1;
      if (writes_rf(c)) begin
        m_we    = 1'b1;
        m_waddr = c[14:10];
        m_wdata = exp_data(b[31:0], c);
      end
    end
    if (do_push) q.push_back({ctrl, tdata});
    m_tready = (q.size() < DEPTH);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("tready", 32'(tready), 32'(m_tready));
    check("rf_we", 32'(rf_we), 32'(m_we));
    check("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
    check("rf_wdata", rf_wdata, m_wdata);
    check("retired_count", retired, exp_retired());
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [16:0] c);
    int n;
    n = 0;
    tdata  = d;
    ctrl   = c;
    tvalid = 1'b1;
    do begin
      tick();
      n++;
    end while (!last_push && n < 50);
    if (!last_push) begin
      vectors++;
      miscompares++;
      $display("FAIL send_beat: handshake not reached after %0d cycles", n);
    end
    tvalid = 1'b0;
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    model_reset();
    #1;
    compare_all();
    check("rst_pulse_we", 32'(rf_we), 32'd0);
    check("rst_pulse_tready", 32'(tready), 32'd0);
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [16:0] rand_ctrl();
    logic [6:0] op;
    int rd;
    case ($urandom_range(0, 8))
      0, 1:    op = LOAD;
      2:       op = OP;
      3:       op = 7'b0010011;
      4:       op = 7'b0110111;
      5:       op = 7'b0010111;
      6:       op = 7'b1101111;
      7:       op = STORE;
      default: op = 7'b1100011;
    endcase
    rd = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 31));
    return mk(int'($urandom_range(0, 3)), rd, int'($urandom_range(0, 7)), op);
  endfunction

  initial begin
    model_reset();
    #1 rst = 1'b1;
    #2;
    compare_all();
    tick();
    tick();
    check("reset_tready", 32'(tready), 32'd0);
    check("reset_we", 32'(rf_we), 32'd0);
    check("reset_wdata", rf_wdata, 32'd0);
    rst = 1'b0;
    tick();
    check("release_tready", 32'(tready), 32'd1);
    tick();
    tick();
    check("idle_we", 32'(rf_we), 32'd0);

    // Directed beats with hand-computed results.
    send_beat(32'h0000_8100, mk(1, 5, 3'b000, LOAD));
    tick();
    check("lb_we", 32'(rf_we), 32'd1);
    check("lb_waddr", 32'(rf_waddr), 32'd5);
    check("lb_wdata", rf_wdata, 32'hFFFF_FF81);

    send_beat(32'hBEEF_0000, mk(2, 3, 3'b101, LOAD));
    tick();
    check("lhu_waddr", 32'(rf_waddr), 32'd3);
    check("lhu_wdata", rf_wdata, 32'h0000_BEEF);

    send_beat(32'd42, mk(0, 7, 3'b010, LOAD));
    tick();
    check("lw_we", 32'(rf_we), 32'd1);
    check("lw_wdata", rf_wdata, 32'd42);

    send_beat(32'd30, mk(0, 0, 3'b000, OP));
    tick();
    check("rd0_we", 32'(rf_we), 32'd0);
    check("rd0_hold_waddr", 32'(rf_waddr), 32'd7);
    check("rd0_hold_wdata", rf_wdata, 32'd42);

    send_beat(32'h1234_5678, mk(0, 9, 3'b010, STORE));
    tick();
    check("store_we", 32'(rf_we), 32'd0);
`ifdef WB_RETIRE_COUNTER_EN
    check("retired_after_5", retired, 32'd5);
`else
    check("retired_tied", retired, 32'd0);
`endif

    // Stall: two beats fill the FIFO, the third waits upstream.
    stall = 1'b1;
    send_beat(32'd11, mk(0, 1, 0, OP));
    send_beat(32'd22, mk(0, 2, 0, OP));
    tdata  = 32'd33;
    ctrl   = mk(0, 3, 0, OP);
    tvalid = 1'b1;
    tick();
    check("full_tready", 32'(tready), 32'd0);
    check("full_we", 32'(rf_we), 32'd0);
    tick();
    check("full_hold_tready", 32'(tready), 32'd0);
    stall = 1'b0;
    tick();
    check("order1_waddr", 32'(rf_waddr), 32'd1);
    check("order1_wdata", rf_wdata, 32'd11);
    check("order1_tready", 32'(tready), 32'd1);
    tick();
    tvalid = 1'b0;
    check("order2_we", 32'(rf_we), 32'd1);
    check("order2_waddr", 32'(rf_waddr), 32'd2);
    tick();
    check("order3_we", 32'(rf_we), 32'd1);
    check("order3_waddr", 32'(rf_waddr), 32'd3);
    check("order3_wdata", rf_wdata, 32'd33);

    // Reset with two beats buffered: they must never be written.
    stall = 1'b1;
    send_beat(32'd44, mk(0, 4, 0, OP));
    send_beat(32'd66, mk(0, 6, 0, OP));
    pulse_reset();
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_we", 32'(rf_we), 32'd0);
    end

    // Randomized traffic with varying stall pressure.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!tvalid || last_push) begin
        if ($urandom_range(0, 99) < 65) begin
          tvalid = 1'b1;
          tdata  = $urandom();
          ctrl   = rand_ctrl();
        end else begin
          tvalid = 1'b0;
        end
      end
      stall = ($urandom_range(0, 99) < ((cyc / 500) % 2 == 0 ? 25 : 70));
      if (cyc == 1500) pulse_reset();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
